gpu_core_seq: RTL and testbench



---
 rtl/gpu_core_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_gpu_core_seq.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_core_seq.sv
// Multi-cycle predicated shader core: fetch/decode/exec with register file, data memory and work-queue push.
// Latency: ALU ops commit 2 cycles after the instruction fetch; LD/ST and QPUSH add 1 cycle plus handshake wait.
// Backpressure: imem, dmem and queue requests are held stable until valid/ack/ready; optional GPU_CORE_MUL_EN enables MUL.
module gpu_core_seq #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16,
    parameter int PC_W   = 16,
    parameter int QID_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [PC_W-1:0]   start_pc,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_valid,
    input  logic [31:0]       imem_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              q_valid,
    output logic [QID_W-1:0]  q_id,
    output logic [DATA_W-1:0] q_data,
    input  logic              q_ready
);

    localparam logic [4:0] OP_LD  = 5'd0,  OP_ST  = 5'd1,  OP_MUL = 5'd2,  OP_ADD = 5'd3;
    localparam logic [4:0] OP_SUB = 5'd4,  OP_AND = 5'd5,  OP_OR  = 5'd6,  OP_XOR = 5'd7;
    localparam logic [4:0] OP_SHL = 5'd8,  OP_SHR = 5'd9,  OP_SLT = 5'd10, OP_SEQ = 5'd11;
    localparam logic [4:0] OP_MOV = 5'd12, OP_BR  = 5'd13, OP_NOP = 5'd14, OP_QPC = 5'd15;
    localparam logic [4:0] OP_QPR = 5'd16, OP_END = 5'd17;

`ifdef GPU_CORE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_QUEUE, S_HALT
    } state_t;

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [31:0]       instr;
    logic [DATA_W-1:0] regs [NREGS];
    logic              p_flag;
    logic              pass_q;
    logic              ill_q;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_s;
    logic [QID_W-1:0]  qid_v;

    logic [1:0]        i_pred;
    logic              i_imm;
    logic [4:0]        i_op;
    logic [3:0]        i_r1;
    logic [3:0]        i_r2;
    logic [15:0]       i_const;

    assign {i_pred, i_imm, i_op, i_r1, i_r2, i_const} = instr;
    assign imem_addr = pc;

    logic              pred_ok;
    logic              uses_r1;
    logic              uses_r2;
    logic              illegal;
    logic [DATA_W-1:0] src_val;
    logic [QID_W-1:0]  qid_val;
    logic [DATA_W-1:0] shamt;
    logic [DATA_W-1:0] alu_res;

    always_comb begin
        case (i_pred)
            2'd0:    pred_ok = 1'b1;
            2'd1:    pred_ok = p_flag;
            2'd2:    pred_ok = !p_flag;
            default: pred_ok = 1'b0;
        endcase
    end

    // Register fields only matter for ops that actually read them.
    assign uses_r1 = !(i_op inside {OP_BR, OP_NOP, OP_END});
    assign uses_r2 = (!i_imm && i_op <= OP_MOV) || i_op == OP_QPR;
    assign illegal = (i_op > OP_END)
                   || (uses_r1 && 32'(i_r1) >= NREGS)
                   || (uses_r2 && 32'(i_r2) >= NREGS)
                   || (i_op == OP_MUL && !MUL_EN);

    assign src_val = i_imm ? DATA_W'(i_const) : regs[i_r2];
    assign qid_val = (i_op == OP_QPR) ? regs[i_r2][QID_W-1:0] : QID_W'(i_const);
    assign shamt   = DATA_W'(32'(op_s) % DATA_W);

    always_comb begin
        alu_res = op_a;
        case (i_op)
`ifdef GPU_CORE_MUL_EN
            OP_MUL:  alu_res = op_a * op_s;
`endif
            OP_ADD:  alu_res = op_a + op_s;
            OP_SUB:  alu_res = op_a - op_s;
            OP_AND:  alu_res = op_a & op_s;
            OP_OR:   alu_res = op_a | op_s;
            OP_XOR:  alu_res = op_a ^ op_s;
            OP_SHL:  alu_res = op_a << shamt;
            OP_SHR:  alu_res = op_a >> shamt;
            default: alu_res = op_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= '0;
            instr      <= '0;
            p_flag     <= 1'b0;
            pass_q     <= 1'b0;
            ill_q      <= 1'b0;
            op_a       <= '0;
            op_s       <= '0;
            qid_v      <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            q_valid    <= 1'b0;
            q_id       <= '0;
            q_data     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc       <= start_pc;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        instr    <= imem_data;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    pass_q <= pred_ok;
                    ill_q  <= illegal;
                    op_a   <= regs[i_r1];
                    op_s   <= src_val;
                    qid_v  <= qid_val;
                    state  <= S_EXEC;
                end
                S_EXEC: begin
                    if (pass_q && ill_q) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_HALT;
                    end else if (pass_q && i_op == OP_END) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_HALT;
                    end else if (pass_q && (i_op == OP_LD || i_op == OP_ST)) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= (i_op == OP_ST);
                        dmem_addr  <= op_s;
                        dmem_wdata <= op_a;
                        state      <= S_MEM;
                    end else if (pass_q && (i_op == OP_QPC || i_op == OP_QPR)) begin
                        q_valid <= 1'b1;
                        q_id    <= qid_v;
                        q_data  <= op_a;
                        state   <= S_QUEUE;
                    end else begin
                        // Squashed instructions fall through here with no side effect.
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                        pc       <= (pass_q && i_op == OP_BR) ? PC_W'(i_const) : pc + 1'b1;
                        if (pass_q) begin
                            case (i_op)
                                OP_SLT:        p_flag <= (op_a < op_s);
                                OP_SEQ:        p_flag <= (op_a == op_s);
                                OP_MOV:        regs[i_r1] <= op_s;
                                OP_BR, OP_NOP: ;
                                default:       regs[i_r1] <= alu_res;
                            endcase
                        end
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (!dmem_we) regs[i_r1] <= dmem_rdata;
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        dmem_addr  <= '0;
                        dmem_wdata <= '0;
                        pc         <= pc + 1'b1;
                        imem_req   <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
                S_QUEUE: begin
                    if (q_ready) begin
                        q_valid  <= 1'b0;
                        q_id     <= '0;
                        q_data   <= '0;
                        pc       <= pc + 1'b1;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_core_seq.sv
// Bench for gpu_core_seq: directed programs plus random programs checked against an instruction-level model.
module tb_gpu_core_seq;

    logic        clk, rst_n, start;
    logic [15:0] start_pc;
    logic        busy, done, err;
    logic        imem_req, imem_valid;
    logic [15:0] imem_addr;
    logic [31:0] imem_data;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        q_valid, q_ready;
    logic [3:0]  q_id;
    logic [15:0] q_data;

    gpu_core_seq #(.DATA_W(16), .NREGS(16), .PC_W(16), .QID_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
        .busy(busy), .done(done), .err(err),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .q_valid(q_valid), .q_id(q_id), .q_data(q_data), .q_ready(q_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] imem   [65536];
    logic [15:0] tb_dmem[65536];
    logic [15:0] m_dmem [65536];
    logic [15:0] mr[16];
    bit          mP;
    bit          m_err;
    logic [15:0] exp_d[$];
    logic [3:0]  exp_id[$];

    bit          imem_hold = 1'b0;
    int          dmem_lat = 0;
    int          q_lat = 0;
    int          fetch_cyc[$];
    logic [32:0] dtx[$];
    int          dlen[$];
    bit          dbad[$];
    logic [15:0] got_d[$];
    logic [3:0]  got_id[$];
    int          qlen[$];
    bit          qbad[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    function automatic logic [31:0] ins(input int pred, input int imm, input int op,
                                        input int r1, input int r2, input int c);
        logic [31:0] w;
        w = {pred[1:0], imm[0], op[4:0], r1[3:0], r2[3:0], c[15:0]};
        return w;
    endfunction

    // Instruction memory: answers in the same cycle the request is seen.
    always @(negedge clk) begin
        if (imem_req && !imem_hold) begin
            imem_valid = 1'b1;
            imem_data  = imem[imem_addr];
            fetch_cyc.push_back(cyc);
        end else begin
            imem_valid = 1'b0;
        end
    end

    int          dcnt = 0;
    logic [32:0] d_first;
    bit          d_bad;
    always @(negedge clk) begin
        dmem_ack = 1'b0;
        if (dmem_req) begin
            if (dcnt == 0) begin
                d_first = {dmem_we, dmem_addr, dmem_wdata};
                d_bad   = 1'b0;
            end else if ({dmem_we, dmem_addr, dmem_wdata} !== d_first) begin
                d_bad = 1'b1;
            end
            if (dcnt >= dmem_lat) begin
                dmem_ack = 1'b1;
                if (dmem_we) tb_dmem[dmem_addr] = dmem_wdata;
                else         dmem_rdata = tb_dmem[dmem_addr];
                dtx.push_back(d_first);
                dlen.push_back(dcnt + 1);
                dbad.push_back(d_bad);
                dcnt = 0;
            end else begin
                dcnt++;
            end
        end else begin
            dcnt = 0;
        end
    end

    int          qcnt = 0;
    logic [19:0] q_first;
    bit          q_bad;
    always @(negedge clk) begin
        q_ready = 1'b0;
        if (q_valid) begin
            if (qcnt == 0) begin
                q_first = {q_id, q_data};
                q_bad   = 1'b0;
            end else if ({q_id, q_data} !== q_first) begin
                q_bad = 1'b1;
            end
            if (qcnt >= q_lat) begin
                q_ready = 1'b1;
                got_d.push_back(q_data);
                got_id.push_back(q_id);
                qlen.push_back(qcnt + 1);
                qbad.push_back(q_bad);
                qcnt = 0;
            end else begin
                qcnt++;
            end
        end else begin
            qcnt = 0;
        end
    end

    // Instruction-level reference: executes the program directly, one instruction per step.
    task automatic model_run(input logic [15:0] spc);
        logic [15:0] pc, pc_n, src, c;
        logic [31:0] w;
        logic [4:0]  op;
        logic [3:0]  r1, r2;
        bit          pass, run_on;
        pc = spc;
        run_on = 1'b1;
        m_err = 1'b0;
        exp_d.delete();
        exp_id.delete();
        for (int g = 0; g < 4000 && run_on; g++) begin
            w = imem[pc];
            op = w[28:24]; r1 = w[23:20]; r2 = w[19:16]; c = w[15:0];
            case (w[31:30])
                2'd0:    pass = 1'b1;
                2'd1:    pass = mP;
                2'd2:    pass = !mP;
                default: pass = 1'b0;
            endcase
            src = w[29] ? c : mr[r2];
            pc_n = pc + 16'd1;
            if (pass) begin
                case (op)
                    5'd0:  mr[r1] = m_dmem[src];
                    5'd1:  m_dmem[src] = mr[r1];
`ifdef GPU_CORE_MUL_EN
                    5'd2:  mr[r1] = 16'((32'(mr[r1]) * 32'(src)) & 32'hFFFF);
`endif
                    5'd3:  mr[r1] = mr[r1] + src;
                    5'd4:  mr[r1] = mr[r1] - src;
                    5'd5:  mr[r1] = mr[r1] & src;
                    5'd6:  mr[r1] = mr[r1] | src;
                    5'd7:  mr[r1] = mr[r1] ^ src;
                    5'd8:  mr[r1] = mr[r1] << (src % 16);
                    5'd9:  mr[r1] = mr[r1] >> (src % 16);
                    5'd10: mP = (mr[r1] < src);
                    5'd11: mP = (mr[r1] == src);
                    5'd12: mr[r1] = src;
                    5'd13: pc_n = c;
                    5'd14: ;
                    5'd15: begin exp_d.push_back(mr[r1]); exp_id.push_back(c[3:0]); end
                    5'd16: begin exp_d.push_back(mr[r1]); exp_id.push_back(mr[r2][3:0]); end
                    5'd17: run_on = 1'b0;
                    default: begin m_err = 1'b1; run_on = 1'b0; end
                endcase
            end
            pc = pc_n;
        end
    endtask

    task automatic run(input logic [15:0] spc, output bit done_seen);
        int n;
        fetch_cyc.delete(); dtx.delete(); dlen.delete(); dbad.delete();
        got_d.delete(); got_id.delete(); qlen.delete(); qbad.delete();
        @(negedge clk);
        start_pc = spc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        done_seen = done;
        chk("run_finished", busy, 0);
    endtask

    int ops[13] = '{0, 1, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 14};

    initial begin
        bit ds;
        int op, imm, c;
        logic [15:0] base;

        for (int i = 0; i < 65536; i++) begin
            imem[i]    = ins(0, 0, 17, 0, 0, 0);
            tb_dmem[i] = 16'(i) ^ 16'hA5A5;
        end
        rst_n = 1'b0; start = 1'b0; start_pc = '0;
        imem_valid = 1'b0; imem_data = '0; dmem_ack = 1'b0; dmem_rdata = '0; q_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_q_valid", q_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // MOV/MOV/ADD with zero-wait memory
        imem[16'h10] = ins(0, 1, 12, 1, 0, 5);
        imem[16'h11] = ins(0, 1, 12, 2, 0, 7);
        imem[16'h12] = ins(0, 0, 3, 1, 2, 0);
        imem[16'h13] = ins(0, 1, 15, 1, 0, 0);
        imem[16'h14] = ins(0, 0, 17, 0, 0, 0);
        run(16'h10, ds);
        chk("add_done", ds, 1);
        chk("add_npush", got_d.size(), 1);
        chk("add_r1", got_d[0], 12);
        chk("add_fetch_gap", fetch_cyc[3] - fetch_cyc[2], 3);
        @(negedge clk);
        chk("done_pulse_width", done, 0);

        // Wrap-around add, SLT predicate, squash, branch
        imem[16'h20] = ins(0, 1, 12, 1, 0, 'hFFFF);
        imem[16'h21] = ins(0, 1, 3, 1, 0, 2);
        imem[16'h22] = ins(0, 1, 15, 1, 0, 1);
        imem[16'h23] = ins(0, 1, 10, 1, 0, 2);
        imem[16'h24] = ins(2, 1, 12, 3, 0, 9);
        imem[16'h25] = ins(1, 1, 12, 4, 0, 4);
        imem[16'h26] = ins(3, 1, 20, 0, 0, 0);
        imem[16'h27] = ins(0, 1, 13, 0, 0, 'h40);
        imem[16'h40] = ins(0, 1, 12, 7, 0, 'h13);
        imem[16'h41] = ins(0, 1, 15, 3, 0, 2);
        imem[16'h42] = ins(0, 0, 16, 4, 7, 0);
        imem[16'h43] = ins(0, 0, 17, 0, 0, 0);
        run(16'h20, ds);
        chk("pred_err", err, 0);
        chk("pred_npush", got_d.size(), 3);
        chk("wrap_add_r1", got_d[0], 16'h0001);
        chk("squashed_r3", got_d[1], 0);
        chk("taken_r4", got_d[2], 4);
        chk("qpush_reg_id", got_id[2], 3);

        // Store then load with delayed ack
        dmem_lat = 3;
        imem[16'h50] = ins(0, 1, 12, 1, 0, 'h1234);
        imem[16'h51] = ins(0, 1, 1, 1, 0, 'h10);
        imem[16'h52] = ins(0, 1, 0, 5, 0, 'h10);
        imem[16'h53] = ins(0, 1, 15, 5, 0, 5);
        imem[16'h54] = ins(0, 0, 17, 0, 0, 0);
        run(16'h50, ds);
        chk("st_req_cycles", dlen[0], 4);
        chk("st_stable", dbad[0], 0);
        chk("st_fields", dtx[0], {1'b1, 16'h0010, 16'h1234});
        chk("st_mem", tb_dmem[16'h10], 16'h1234);
        chk("ld_req_cycles", dlen[1], 4);
        chk("ld_value", got_d[0], 16'h1234);
        chk("st_fetch_gap", fetch_cyc[2] - fetch_cyc[1], 7);
        dmem_lat = 0;

        // Queue push held off by q_ready
        q_lat = 5;
        imem[16'h60] = ins(0, 1, 12, 2, 0, 'h55);
        imem[16'h61] = ins(0, 1, 15, 2, 0, 3);
        imem[16'h62] = ins(0, 0, 17, 0, 0, 0);
        run(16'h60, ds);
        chk("q_data", got_d[0], 16'h55);
        chk("q_id", got_id[0], 3);
        chk("q_valid_cycles", qlen[0], 6);
        chk("q_stable", qbad[0], 0);
        chk("q_fetch_gap", fetch_cyc[2] - fetch_cyc[1], 9);
        q_lat = 0;

        // Illegal opcode
        imem[16'h70] = ins(0, 1, 20, 0, 0, 0);
        run(16'h70, ds);
        chk("ill_err", err, 1);
        chk("ill_no_done", ds, 0);

        // PC wrap; restart also clears err
        imem[16'hFFFF] = ins(0, 1, 12, 6, 0, 6);
        imem[16'h0000] = ins(0, 1, 15, 6, 0, 6);
        imem[16'h0001] = ins(0, 0, 17, 0, 0, 0);
        run(16'hFFFF, ds);
        chk("wrap_err_cleared", err, 0);
        chk("wrap_push", got_d.size() == 1 ? got_d[0] : 16'hDEAD, 6);
        chk("wrap_done", ds, 1);

        // Multiply
        imem[16'h80] = ins(0, 1, 12, 1, 0, 'h0102);
        imem[16'h81] = ins(0, 1, 2, 1, 0, 'h0103);
        imem[16'h82] = ins(0, 1, 15, 1, 0, 0);
        imem[16'h83] = ins(0, 0, 17, 0, 0, 0);
        run(16'h80, ds);
`ifdef GPU_CORE_MUL_EN
        chk("mul_err", err, 0);
        chk("mul_value", got_d.size() == 1 ? got_d[0] : 16'hDEAD, 16'h0506);
`else
        chk("mul_err", err, 1);
        chk("mul_no_push", got_d.size(), 0);
`endif

        // Reset while fetch is pending
        imem_hold = 1'b1;
        imem[16'h90] = ins(0, 1, 15, 1, 0, 1);
        imem[16'h91] = ins(0, 1, 15, 5, 0, 5);
        imem[16'h92] = ins(0, 0, 17, 0, 0, 0);
        @(negedge clk);
        start_pc = 16'h90;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("midfetch_req", imem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midfetch_rst_req", imem_req, 0);
        chk("midfetch_rst_busy", busy, 0);
        chk("midfetch_rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        imem_hold = 1'b0;
        run(16'h90, ds);
        chk("post_rst_r1", got_d.size() == 2 ? got_d[0] : 16'hDEAD, 0);
        chk("post_rst_r5", got_d.size() == 2 ? got_d[1] : 16'hDEAD, 0);

        // Random programs; architectural state is all-zero after the reset above
        for (int i = 0; i < 16; i++) mr[i] = '0;
        mP = 1'b0;
        for (int i = 0; i < 65536; i++) m_dmem[i] = tb_dmem[i];
        for (int r = 0; r < 16; r++) begin
            base = 16'h0400 + 16'(r * 64);
            for (int i = 0; i < 24; i++) begin
                op  = ops[$urandom_range(0, 12)];
                imm = $urandom_range(0, 1);
                c   = (op <= 1) ? $urandom_range(0, 63) : $urandom_range(0, 65535);
                imem[int'(base) + i] = ins($urandom_range(0, 3), imm, op,
                                           $urandom_range(0, 15), $urandom_range(0, 15), c);
            end
            for (int k = 0; k < 16; k++) imem[int'(base) + 24 + k] = ins(0, 1, 15, k, 0, k);
            imem[int'(base) + 40] = ins(0, 0, 17, 0, 0, 0);
            model_run(base);
            dmem_lat = $urandom_range(0, 3);
            q_lat    = $urandom_range(0, 3);
            run(base, ds);
            chk("rnd_err", err, m_err);
            chk("rnd_done", ds, !m_err);
            chk("rnd_npush", got_d.size(), exp_d.size());
            for (int k = 0; k < exp_d.size() && k < got_d.size(); k++) begin
                chk($sformatf("rnd%0d_data%0d", r, k), got_d[k], exp_d[k]);
                chk($sformatf("rnd%0d_id%0d", r, k), got_id[k], exp_id[k]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
